// File: rtl/metronome_seq.sv
// metronome_seq: tempo-driven step sequencer with per-step click bursts, square-wave tone and one-hot step LEDs.
// Optional feature: define ACCENT_EN so the accent input selects the higher ACC_HZ click pitch.
module metronome_seq #(
  parameter int CLK_HZ    = 25000000,
  parameter int SUBDIV    = 4,
  parameter int STEPS     = 16,
  parameter int BPM_W     = 8,
  parameter int TONE_HZ   = 2500,
  parameter int ACC_HZ    = 5000,
  parameter int CLICK_CYC = 2500000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [BPM_W-1:0]         bpm,
  input  logic [$clog2(STEPS)-1:0] len,
  input  logic [STEPS-1:0]         pattern,
  input  logic [STEPS-1:0]         accent,
  output logic [$clog2(STEPS)-1:0] step_idx,
  output logic                     step_tick,
  output logic [STEPS-1:0]         led,
  output logic                     bell,
  output logic                     clicking
);

  localparam int     IDX_W     = $clog2(STEPS);
  localparam longint PERIOD_L  = longint'(CLK_HZ) * 64'd60;
  localparam int     ACC_W     = $clog2(PERIOD_L + (64'd1 << BPM_W) * longint'(SUBDIV));
  localparam int     TONE_HALF = CLK_HZ / (2 * TONE_HZ);
  localparam int     ACC_HALF  = CLK_HZ / (2 * ACC_HZ);
  localparam int     HALF_MAX  = (TONE_HALF > ACC_HALF) ? TONE_HALF : ACC_HALF;
  localparam int     HALF_W    = $clog2(HALF_MAX + 1);
  localparam int     BURST_W   = $clog2(CLICK_CYC + 1);

  localparam logic [ACC_W-1:0]   PERIOD   = ACC_W'(PERIOD_L);
  localparam logic [HALF_W-1:0]  TONE_M1  = HALF_W'(TONE_HALF - 1);
  localparam logic [BURST_W-1:0] BURST_LD = BURST_W'(CLICK_CYC - 1);
  localparam logic [STEPS-1:0]   LED_ONE  = STEPS'(1);
  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(STEPS - 1);

  logic [ACC_W-1:0]   r_acc;
  logic               r_en_d;
  logic [IDX_W-1:0]   r_idx;
  logic               r_tick;
  logic [STEPS-1:0]   r_led;
  logic [BURST_W-1:0] r_burst;
  logic [HALF_W-1:0]  r_tone;
  logic [HALF_W-1:0]  r_half_m1;
  logic               r_bell;
  logic               r_clicking;

  logic [ACC_W-1:0]   w_inc;
  logic [ACC_W-1:0]   w_sum;
  logic               w_rise;
  logic               w_adv;
  logic               w_wrap;
  logic               w_tick;
  logic               w_click;
  logic [IDX_W-1:0]   w_idx_nxt;
  logic [HALF_W-1:0]  w_half_m1;

  assign w_inc  = ACC_W'(bpm) * ACC_W'(SUBDIV);
  assign w_sum  = r_acc + w_inc;
  assign w_rise = en & ~r_en_d;
  assign w_adv  = en & r_en_d & (w_sum >= PERIOD);
  assign w_wrap = (r_idx >= len) || (r_idx == IDX_LAST);
  assign w_tick = w_rise | w_adv;

  always_comb begin
    w_idx_nxt = r_idx;
    if (w_rise)
      w_idx_nxt = '0;
    else if (w_adv)
      w_idx_nxt = w_wrap ? '0 : r_idx + IDX_W'(1);
  end

  assign w_click = w_tick & pattern[w_idx_nxt];

`ifdef ACCENT_EN
  localparam logic [HALF_W-1:0] ACC_M1 = HALF_W'(ACC_HALF - 1);
  assign w_half_m1 = accent[w_idx_nxt] ? ACC_M1 : TONE_M1;
`else
  logic w_unused_accent;
  assign w_unused_accent = ^accent;
  assign w_half_m1       = TONE_M1;
`endif

  // Stage 1: phase accumulator, step index and LED bar; the first enabled cycle restarts at step 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc  <= '0;
      r_en_d <= 1'b0;
      r_idx  <= '0;
      r_tick <= 1'b0;
      r_led  <= '0;
    end else if (!en) begin
      r_acc  <= '0;
      r_en_d <= 1'b0;
      r_idx  <= '0;
      r_tick <= 1'b0;
      r_led  <= '0;
    end else begin
      r_en_d <= 1'b1;
      r_acc  <= w_rise ? '0 : (w_adv ? w_sum - PERIOD : w_sum);
      r_idx  <= w_idx_nxt;
      r_tick <= w_tick;
      r_led  <= LED_ONE << w_idx_nxt;
    end
  end

  // Stage 2: click burst and tone generator; a new click always restarts the burst and its pitch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_burst    <= '0;
      r_tone     <= '0;
      r_half_m1  <= TONE_M1;
      r_bell     <= 1'b0;
      r_clicking <= 1'b0;
    end else if (!en) begin
      r_burst    <= '0;
      r_tone     <= '0;
      r_bell     <= 1'b0;
      r_clicking <= 1'b0;
    end else if (w_click) begin
      r_burst    <= BURST_LD;
      r_tone     <= '0;
      r_half_m1  <= w_half_m1;
      r_bell     <= 1'b0;
      r_clicking <= 1'b1;
    end else if (r_clicking) begin
      if (r_burst == '0) begin
        r_clicking <= 1'b0;
        r_bell     <= 1'b0;
        r_tone     <= '0;
      end else begin
        r_burst <= r_burst - BURST_W'(1);
        if (r_tone == r_half_m1) begin
          r_bell <= ~r_bell;
          r_tone <= '0;
        end else begin
          r_tone <= r_tone + HALF_W'(1);
        end
      end
    end
  end

  assign step_idx  = r_idx;
  assign step_tick = r_tick;
  assign led       = r_led;
  assign bell      = r_bell;
  assign clicking  = r_clicking;

endmodule

// File: tb/tb_metronome_seq.sv
// Scoreboard bench for metronome_seq: a tempo/step/click reference model queues per-cycle expectations, a monitor compares.
module tb_metronome_seq;
  localparam int CLK_HZ    = 1600;
  localparam int SUBDIV    = 4;
  localparam int STEPS     = 16;
  localparam int BPM_W     = 8;
  localparam int TONE_HZ   = 100;
  localparam int ACC_HZ    = 200;
  localparam int CLICK_CYC = 64;
  localparam int PERIOD    = CLK_HZ * 60;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [7:0]  bpm;
  logic [3:0]  len;
  logic [15:0] pattern;
  logic [15:0] accent;
  logic [3:0]  step_idx;
  logic        step_tick;
  logic [15:0] led;
  logic        bell;
  logic        clicking;

  metronome_seq #(
    .CLK_HZ(CLK_HZ), .SUBDIV(SUBDIV), .STEPS(STEPS), .BPM_W(BPM_W),
    .TONE_HZ(TONE_HZ), .ACC_HZ(ACC_HZ), .CLICK_CYC(CLICK_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .bpm(bpm), .len(len),
    .pattern(pattern), .accent(accent), .step_idx(step_idx),
    .step_tick(step_tick), .led(led), .bell(bell), .clicking(clicking)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        tick;
    logic [3:0]  idx;
    logic [15:0] led;
    logic        clicking;
    logic        bell;
  } rec_t;

  rec_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  int   m_cyc = 0;
  int   m_phase = 0;
  int   m_idx = 0;
  bit   m_en_prev = 1'b0;
  bit   m_burst = 1'b0;
  int   m_start = 0;
  int   m_half = 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, m_cyc);
    end
  endtask

  // Reference model: phase arithmetic, step rule and closed-form click waveform, one record per clock
  always @(posedge clk) begin : model
    rec_t r;
    bit   tk;
    int   d;
    tk = 1'b0;
    m_cyc++;
    if (!rst_n || !en) begin
      m_phase   = 0;
      m_idx     = 0;
      m_en_prev = 1'b0;
      m_burst   = 1'b0;
    end else begin
      if (!m_en_prev) begin
        m_en_prev = 1'b1;
        m_phase   = 0;
        m_idx     = 0;
        tk        = 1'b1;
      end else begin
        m_phase = m_phase + int'(bpm) * SUBDIV;
        if (m_phase >= PERIOD) begin
          m_phase = m_phase - PERIOD;
          m_idx   = (m_idx >= int'(len) || m_idx == STEPS - 1) ? 0 : m_idx + 1;
          tk      = 1'b1;
        end
      end
      if (tk && pattern[m_idx]) begin
        m_burst = 1'b1;
        m_start = m_cyc;
`ifdef ACCENT_EN
        m_half = accent[m_idx] ? CLK_HZ / (2 * ACC_HZ) : CLK_HZ / (2 * TONE_HZ);
`else
        m_half = CLK_HZ / (2 * TONE_HZ);
`endif
      end
    end
    r.tick = tk;
    r.idx  = 4'(m_idx);
    r.led  = (rst_n && en) ? (16'd1 << m_idx) : 16'd0;
    d = m_cyc - m_start;
    if (m_burst && d < CLICK_CYC) begin
      r.clicking = 1'b1;
      r.bell     = ((d / m_half) % 2) == 1;
    end else begin
      m_burst    = 1'b0;
      r.clicking = 1'b0;
      r.bell     = 1'b0;
    end
    exp_q.push_back(r);
  end

  // Monitor: pop one expectation per clock and compare away from the active edge
  initial begin : monitor
    rec_t r;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard: no expectation queued (cycle %0d)", m_cyc);
      end else begin
        r = exp_q.pop_front();
        check("step", {11'd0, step_tick, step_idx, led}, {11'd0, r.tick, r.idx, r.led});
        check("tone", {30'd0, clicking, bell}, {30'd0, r.clicking, r.bell});
      end
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_tick(input int max_cyc, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!step_tick && n < max_cyc);
    if (!step_tick) begin
      checks++;
      errors++;
      $display("FAIL tick_timeout: got none expected step_tick within %0d cycles", max_cyc);
    end
  endtask

  task automatic wait_idx(input logic [3:0] want, input int max_cyc);
    int n;
    n = 0;
    while (step_idx != want && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    if (step_idx != want) begin
      checks++;
      errors++;
      $display("FAIL idx_timeout: got %0d expected %0d", step_idx, want);
    end
  endtask

  initial begin : stim
    int n;
    logic [3:0] held;
    rst_n = 1'b0; en = 1'b0; bpm = 8'd0; len = 4'd15; pattern = 16'h0; accent = 16'h0;
    repeat (3) @(negedge clk);
    check("rst_idx", 32'(step_idx), 32'd0);
    check("rst_tick", 32'(step_tick), 32'd0);
    check("rst_led", 32'(led), 32'd0);
    check("rst_bell", 32'(bell), 32'd0);
    check("rst_click", 32'(clicking), 32'd0);
    rst_n = 1'b1;
    run(2);

    // Full measure at 60 BPM, accent on step 0 only
    bpm = 8'd60; len = 4'd15; pattern = 16'hFFFF; accent = 16'h0001; en = 1'b1;
    wait_tick(10, n);
    check("first_idx", 32'(step_idx), 32'd0);
    wait_tick(1000, n);
    check("period60", 32'(n), 32'd400);
    run(16 * 400 + 20);

    // Disable in the middle of a burst
    wait_tick(500, n);
    run(10);
    en = 1'b0;
    @(negedge clk);
    check("dis_bell", 32'(bell), 32'd0);
    check("dis_led", 32'(led), 32'd0);
    check("dis_idx", 32'(step_idx), 32'd0);
    check("dis_click", 32'(clicking), 32'd0);
    run(5);

    // Short measure, clicks only on steps 0 and 2, then shrink len while at step 3
    len = 4'd3; pattern = 16'h0005; accent = 16'h0000; en = 1'b1;
    run(5 * 400 + 10);
    wait_idx(4'd3, 2000);
    len = 4'd1;
    wait_tick(1000, n);
    check("len_shrink", 32'(step_idx), 32'd0);

    // Tempo change halfway through a step keeps the accumulated phase
    len = 4'd15; pattern = 16'h1111; bpm = 8'd60;
    wait_tick(1000, n);
    run(200);
    bpm = 8'd120;
    wait_tick(1000, n);
    check("tempo_first", 32'(n), 32'd100);
    wait_tick(1000, n);
    check("tempo_next", 32'(n), 32'd200);

    // Paused tempo holds the step
    run(20);
    bpm = 8'd0;
    held = step_idx;
    run(1000);
    check("pause_hold", 32'(step_idx), 32'(held));

    // Fastest tempo with every step clicking
    bpm = 8'd255; pattern = 16'hFFFF; accent = 16'h5555;
    run(600);

    // Asynchronous reset during a burst
    wait_tick(200, n);
    run(5);
    #1 rst_n = 1'b0;
    #1;
    check("arst_bell", 32'(bell), 32'd0);
    check("arst_click", 32'(clicking), 32'd0);
    check("arst_led", 32'(led), 32'd0);
    check("arst_idx", 32'(step_idx), 32'd0);
    run(2);
    #1 rst_n = 1'b1;
    wait_tick(10, n);
    check("reen_idx", 32'(step_idx), 32'd0);
    run(50);

    // Randomised segments
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      bpm     = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 5) == 0) bpm = 8'd0;
      len     = 4'($urandom_range(0, 15));
      pattern = 16'($urandom);
      accent  = 16'($urandom);
      en      = ($urandom_range(0, 7) != 0);
      run($urandom_range(50, 900));
    end
    run(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
